riscv_store: RTL and testbench

- Store-side counterpart of the load extension path: takes a store request from the MEM stage and drives one aligned 64-bit write to data memory.
- Builds the byte strobe and lane-shifted write data for SB/SH/SW/SD from the address low bits and func_code (funct3).
- Detects misaligned or illegal stores and reports them instead of writing.
- Holds the write stable on a valid/ready memory interface until it is accepted, then signals completion to the pipeline.

---
 rtl/riscv_store_pkg.sv | 38 +++
 rtl/riscv_store_align.sv | 56 +++++
 rtl/riscv_store.sv | 149 ++++++++++++++
 tb/tb_riscv_store.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_store_pkg.sv
// riscv_store_pkg: shared definitions for the store path.
//   - funct3 store codes (SB/SH/SW/SD)
//   - byte-lane count and data width of the write port
//   - helpers that turn a store size into a base strobe and a byte mask
package riscv_store_pkg;

  localparam int LANES  = 8;
  localparam int DATA_W = LANES * 8;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  // Strobe for a store of this size placed at lane 0; zero for illegal codes.
  function automatic logic [LANES-1:0] base_strobe(input logic [2:0] f3);
    logic [LANES-1:0] s;
    case (f3)
      F3_SB:   s = 8'h01;
      F3_SH:   s = 8'h03;
      F3_SW:   s = 8'h0F;
      F3_SD:   s = 8'hFF;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Expand each strobe bit into a full byte of ones.
  function automatic logic [DATA_W-1:0] byte_mask(input logic [LANES-1:0] strb);
    logic [DATA_W-1:0] m;
    m = {DATA_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/riscv_store_align.sv
// riscv_store_align: combinational store lane placement and legality check.
// Ports:
//   func_code [2:0]  funct3 of the store
//   addr_off  [2:0]  byte offset within the 64-bit word
//   data      [63:0] store source; only the low size bytes are used
//   wstrb     [7:0]  byte enables (0 when the store faults)
//   wdata     [63:0] data moved to its byte lanes, unused lanes zero
//   misalign         offset not a multiple of the access size
//   illegal          funct3 is not a store code
module riscv_store_align
  import riscv_store_pkg::*;
(
  input  logic [2:0]        func_code,
  input  logic [2:0]        addr_off,
  input  logic [DATA_W-1:0] data,
  output logic [LANES-1:0]  wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic              misalign,
  output logic              illegal
);

  logic [LANES-1:0]  base_s;
  logic [DATA_W-1:0] masked_s;
  logic [5:0]        shamt_s;

  assign base_s   = base_strobe(func_code);
  assign masked_s = data & byte_mask(base_s);
  assign shamt_s  = {addr_off, 3'b000};

  // Legality: size-natural alignment, and funct3[2] set is never a store.
  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    case (func_code)
      F3_SB:   misalign = 1'b0;
      F3_SH:   misalign = addr_off[0];
      F3_SW:   misalign = |addr_off[1:0];
      F3_SD:   misalign = |addr_off;
      default: illegal  = 1'b1;
    endcase
  end

  // Lane placement; the shift is done at full width so nothing wraps past lane 7.
  always_comb begin
    wstrb = 8'h00;
    wdata = {DATA_W{1'b0}};
    if (misalign || illegal) begin
      wstrb = 8'h00;
      wdata = {DATA_W{1'b0}};
    end else begin
      wstrb = base_s << addr_off;
      wdata = masked_s << shamt_s;
    end
  end

endmodule

// File: rtl/riscv_store.sv
// riscv_store: MEM-stage store unit driving one aligned 64-bit memory write.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   store request handshake (ready only in IDLE)
//   req_addr, req_data    byte address and rs2 source
//   func_code             funct3 (SB/SH/SW/SD, 1xx illegal)
//   mem_wvalid/mem_wready write handshake to data memory
//   mem_waddr/wdata/wstrb aligned address, lane-shifted data, byte enables
//   store_done            one-cycle pulse after the write is accepted
//   store_err, err_addr   one-cycle pulse plus address for a faulting store
module riscv_store
  import riscv_store_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  input  logic [2:0]        func_code,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [7:0]        mem_wstrb,
  output logic              store_done,
  output logic              store_err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_next_s;

  logic [LANES-1:0]  al_strb_s;
  logic [WIDTH-1:0]  al_data_s;
  logic              al_misalign_s;
  logic              al_illegal_s;
  logic              fault_s;
  logic              accept_s;

  logic              mem_wvalid_r;
  logic [ADDR_W-1:0] mem_waddr_r;
  logic [WIDTH-1:0]  mem_wdata_r;
  logic [7:0]        mem_wstrb_r;
  logic              store_done_r;
  logic              store_err_r;
  logic [ADDR_W-1:0] err_addr_r;

  riscv_store_align u_align (
    .func_code (func_code),
    .addr_off  (req_addr[2:0]),
    .data      (req_data),
    .wstrb     (al_strb_s),
    .wdata     (al_data_s),
    .misalign  (al_misalign_s),
    .illegal   (al_illegal_s)
  );

  assign fault_s  = al_misalign_s | al_illegal_s;
  assign accept_s = (state_r == ST_IDLE) & req_valid;

  // Ready depends on state only so upstream never sees a combinational loop.
  assign req_ready = (state_r == ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; BUSY only leaves on a completed write handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (fault_s) begin
            state_next_s = ST_ERR;
          end else begin
            state_next_s = ST_BUSY;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_wready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_ERR:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Registered outputs; write payload is captured once and held until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wvalid_r <= 1'b0;
      mem_waddr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {WIDTH{1'b0}};
      mem_wstrb_r  <= 8'h00;
      store_done_r <= 1'b0;
      store_err_r  <= 1'b0;
      err_addr_r   <= {ADDR_W{1'b0}};
    end else begin
      mem_wvalid_r <= (state_next_s == ST_BUSY);
      store_done_r <= (state_r == ST_BUSY) & mem_wready;
      store_err_r  <= (state_next_s == ST_ERR);
      if (accept_s && !fault_s) begin
        mem_waddr_r <= {req_addr[ADDR_W-1:3], 3'b000};
        mem_wdata_r <= al_data_s;
        mem_wstrb_r <= al_strb_s;
      end else begin
        mem_waddr_r <= mem_waddr_r;
        mem_wdata_r <= mem_wdata_r;
        mem_wstrb_r <= mem_wstrb_r;
      end
      if (accept_s && fault_s) begin
        err_addr_r <= req_addr;
      end else begin
        err_addr_r <= err_addr_r;
      end
    end
  end

  assign mem_wvalid = mem_wvalid_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wstrb  = mem_wstrb_r;
  assign store_done = store_done_r;
  assign store_err  = store_err_r;
  assign err_addr   = err_addr_r;

endmodule

// File: tb/tb_riscv_store.sv
module tb_riscv_store;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [2:0]  func_code;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        store_done;
  logic        store_err;
  logic [63:0] err_addr;

  int checks;
  int failures;

  riscv_store #(.WIDTH(64), .ADDR_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .func_code  (func_code),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .store_done (store_done),
    .store_err  (store_err),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [2:0]  f3;
    int          wait_cycles;
    bit          exp_err;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: store of 2^f3[1:0] bytes, naturally aligned, bytes copied lane by lane.
  function automatic void ref_store(input logic [2:0] f3, input logic [63:0] addr,
                                    input logic [63:0] data, output bit err,
                                    output logic [7:0] strb, output logic [63:0] wd);
    int size;
    int off;
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    err  = (f3 >= 3'd4) || ((off % size) != 0);
    strb = 8'h00;
    wd   = 64'd0;
    if (!err) begin
      for (int b = 0; b < size; b++) begin
        strb[off+b]         = 1'b1;
        wd[(off+b)*8 +: 8] = data[b*8 +: 8];
      end
    end
  endfunction

  // Issue one store at a negedge and follow it to completion.
  task automatic run_store(input string tag, input logic [63:0] addr, input logic [63:0] data,
                           input logic [2:0] f3, input int wait_cycles, input bit exp_err,
                           input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
    logic [63:0] exp_waddr;
    exp_waddr = addr & ~64'd7;
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    func_code = f3;
    chk({tag, ".ready_before"}, {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_err) begin
      chk({tag, ".err"},      {63'd0, store_err},  64'd1);
      chk({tag, ".err_addr"}, err_addr,            addr);
      chk({tag, ".no_wvalid"},{63'd0, mem_wvalid}, 64'd0);
      chk({tag, ".no_done"},  {63'd0, store_done}, 64'd0);
      chk({tag, ".ready_err"},{63'd0, req_ready},  64'd0);
      @(negedge clk);
      chk({tag, ".err_pulse"},{63'd0, store_err},  64'd0);
      chk({tag, ".ready_t2"}, {63'd0, req_ready},  64'd1);
      chk({tag, ".no_wv_t2"}, {63'd0, mem_wvalid}, 64'd0);
    end else begin
      for (int w = 0; w <= wait_cycles; w++) begin
        mem_wready = (w == wait_cycles);
        chk($sformatf("%s.wvalid[%0d]", tag, w), {63'd0, mem_wvalid}, 64'd1);
        chk($sformatf("%s.waddr[%0d]", tag, w),  mem_waddr,           exp_waddr);
        chk($sformatf("%s.wstrb[%0d]", tag, w),  {56'd0, mem_wstrb},  {56'd0, exp_strb});
        chk($sformatf("%s.wdata[%0d]", tag, w),  mem_wdata,           exp_wdata);
        chk($sformatf("%s.busy_rdy[%0d]", tag, w), {63'd0, req_ready}, 64'd0);
        chk($sformatf("%s.early_done[%0d]", tag, w), {63'd0, store_done}, 64'd0);
        @(negedge clk);
      end
      mem_wready = 1'b0;
      chk({tag, ".done"},      {63'd0, store_done}, 64'd1);
      chk({tag, ".no_err"},    {63'd0, store_err},  64'd0);
      chk({tag, ".ready_t2"},  {63'd0, req_ready},  64'd1);
      chk({tag, ".wv_drop"},   {63'd0, mem_wvalid}, 64'd0);
      @(negedge clk);
      chk({tag, ".done_pulse"},{63'd0, store_done}, 64'd0);
    end
  endtask

  // Done and err must never coincide.
  always @(negedge clk) begin
    if (!rst && store_done && store_err) begin
      failures++;
      $display("FAIL done_err_overlap actual=1 required=0");
    end
  end

  vec_t vecs[12];

  initial begin
    logic [63:0] ra;
    logic [63:0] rd;
    logic [2:0]  rf;
    bit          e_err;
    logic [7:0]  e_strb;
    logic [63:0] e_wd;
    int          n_hs;
    int          n_done;
    int          idx;
    int          last_hs;
    bit          accept;
    logic [63:0] b2b_addr[4];
    logic [63:0] b2b_data[4];

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 64'd0;
    req_data  = 64'd0;
    func_code = 3'd0;
    mem_wready = 1'b0;

    vecs[0]  = '{64'h1003, 64'hDEADBEEFCAFEF0AB, 3'b000, 0, 1'b0, 8'h08, 64'h00000000AB000000};
    vecs[1]  = '{64'h2006, 64'hFFFFFFFFFFFF1234, 3'b001, 0, 1'b0, 8'hC0, 64'h1234000000000000};
    vecs[2]  = '{64'h2004, 64'h5555555589ABCDEF, 3'b010, 0, 1'b0, 8'hF0, 64'h89ABCDEF00000000};
    vecs[3]  = '{64'h3000, 64'h0123456789ABCDEF, 3'b011, 3, 1'b0, 8'hFF, 64'h0123456789ABCDEF};
    vecs[4]  = '{64'h4002, 64'h1111111122222222, 3'b010, 0, 1'b1, 8'h00, 64'h0};
    vecs[5]  = '{64'h4002, 64'h1111111122222222, 3'b101, 0, 1'b1, 8'h00, 64'h0};
    vecs[6]  = '{64'h5001, 64'h000000000000BEEF, 3'b001, 0, 1'b1, 8'h00, 64'h0};
    vecs[7]  = '{64'h6004, 64'hAAAAAAAAAAAAAAAA, 3'b011, 0, 1'b1, 8'h00, 64'h0};
    vecs[8]  = '{64'h7000, 64'h7777777777777781, 3'b000, 1, 1'b0, 8'h01, 64'h0000000000000081};
    vecs[9]  = '{64'h7007, 64'hFFFFFFFFFFFFFF5A, 3'b000, 0, 1'b0, 8'h80, 64'h5A00000000000000};
    vecs[10] = '{64'h8000, 64'h0000000000000001, 3'b111, 0, 1'b1, 8'h00, 64'h0};
    vecs[11] = '{64'h9000, 64'hFFFFFFFFFFFFFFFF, 3'b010, 1, 1'b0, 8'h0F, 64'h00000000FFFFFFFF};

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.req_ready",  {63'd0, req_ready},  64'd1);
    chk("rst.mem_wvalid", {63'd0, mem_wvalid}, 64'd0);
    chk("rst.store_done", {63'd0, store_done}, 64'd0);
    chk("rst.store_err",  {63'd0, store_err},  64'd0);
    chk("rst.mem_waddr",  mem_waddr,           64'd0);
    chk("rst.mem_wdata",  mem_wdata,           64'd0);
    chk("rst.mem_wstrb",  {56'd0, mem_wstrb},  64'd0);
    chk("rst.err_addr",   err_addr,            64'd0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_store($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].f3,
                vecs[i].wait_cycles, vecs[i].exp_err, vecs[i].exp_strb, vecs[i].exp_wdata);
    end

    // Randomized stores against the reference model.
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        ra = ra & ~((64'd1 << rf[1:0]) - 64'd1);
      end
      ref_store(rf, ra, rd, e_err, e_strb, e_wd);
      run_store($sformatf("rnd%0d", i), ra, rd, rf, $urandom_range(0, 3), e_err, e_strb, e_wd);
    end

    // Back-to-back: request held valid, memory always ready.
    for (int k = 0; k < 4; k++) begin
      b2b_addr[k] = 64'hB000 + 64'(k * 8);
      b2b_data[k] = 64'h1010101010101010 * 64'(k + 1);
    end
    mem_wready = 1'b1;
    idx        = 0;
    n_hs       = 0;
    n_done     = 0;
    last_hs    = -10;
    req_valid  = 1'b1;
    req_addr   = b2b_addr[0];
    req_data   = b2b_data[0];
    func_code  = 3'b011;
    for (int c = 0; c < 20; c++) begin
      accept = req_valid && req_ready;
      @(negedge clk);
      if (mem_wvalid && mem_wready) begin
        if (n_hs < 4) begin
          chk($sformatf("b2b.waddr%0d", n_hs), mem_waddr, b2b_addr[n_hs]);
          chk($sformatf("b2b.wdata%0d", n_hs), mem_wdata, b2b_data[n_hs]);
        end
        if (n_hs > 0) begin
          chk($sformatf("b2b.gap%0d", n_hs), 64'(c - last_hs), 64'd2);
        end
        last_hs = c;
        n_hs++;
      end
      if (store_done) n_done++;
      if (accept) begin
        idx++;
        if (idx < 4) begin
          req_addr = b2b_addr[idx];
          req_data = b2b_data[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    mem_wready = 1'b0;
    chk("b2b.handshakes", 64'(n_hs),   64'd4);
    chk("b2b.done_count", 64'(n_done), 64'd4);
    chk("b2b.accepted",   64'(idx),    64'd4);

    // Reset while BUSY with memory stalled.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'hA000;
    req_data  = 64'h0F0F0F0F0F0F0F0F;
    func_code = 3'b011;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.busy_wvalid", {63'd0, mem_wvalid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.wvalid", {63'd0, mem_wvalid}, 64'd0);
    chk("abort.ready",  {63'd0, req_ready},  64'd1);
    chk("abort.done",   {63'd0, store_done}, 64'd0);
    chk("abort.err",    {63'd0, store_err},  64'd0);
    @(negedge clk);
    chk("abort.done_late", {63'd0, store_done}, 64'd0);

    // Reset while in ERR.
    req_valid = 1'b1;
    req_addr  = 64'hC003;
    func_code = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("errabort.err", {63'd0, store_err}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("errabort.err_clr", {63'd0, store_err}, 64'd0);
    chk("errabort.ready",   {63'd0, req_ready}, 64'd1);

    // A normal store still works after the aborts.
    run_store("post", 64'hD002, 64'h00000000000055AA, 3'b001, 0, 1'b0, 8'h0C, 64'h0000000055AA0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
